gp_reg_bank: RTL and testbench

General-purpose register bank and select/encode decoder for the datapath: sixteen 32-bit registers R0–R15 written from `BusMuxOut` and presented back to the bus multiplexer as `gp_output0..15` with one-hot `gp_out[15:0]` drive requests. Register selection comes from the IR's Ra/Rb/Rc fields under control-unit strobes `gra`/`grb`/`grc`. The block is the destination (load) end of the internal bus; the bus multiplexer is the source end.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/reg_sel_decode.sv | 20 ++
 rtl/gp_reg_bank.sv | 131 +++++++++++++
 tb/tb_gp_reg_bank.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath definitions: IR field positions, register count, index type
// and the C-field sign-extension helper.
package cpu_pkg;

    localparam int NREGS  = 16;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;
    localparam int C_MSB  = 18;

    typedef logic [3:0] reg_idx_t;

    // Widen the IR constant field to a full word, replicating its top bit.
    function automatic logic [31:0] sign_extend_c(input logic [C_MSB:0] c_field);
        sign_extend_c = {{(31 - C_MSB){c_field[C_MSB]}}, c_field};
    endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// 4-to-16 one-hot decoder with enable; all-zero output when disabled.
module reg_sel_decode
    import cpu_pkg::*;
(
    input  logic       en,
    input  reg_idx_t   idx,
    output logic [15:0] hot
);

    // One-hot expansion of the selected register index.
    always_comb begin
        hot = 16'h0000;
        if (en) begin
            hot = 16'h0001 << idx;
        end else begin
            hot = 16'h0000;
        end
    end

endmodule

// File: rtl/gp_reg_bank.sv
// Sixteen 32-bit general-purpose registers with IR-field select, one-hot bus
// drive requests and sticky multi-select error. Option: GP_BANK_BA_OUT_EN.
module gp_reg_bank #(
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] BusMuxOut,
    input  logic [31:0] ir,
    input  logic        gra,
    input  logic        grb,
    input  logic        grc,
    input  logic        r_in,
    input  logic        r_out,
    input  logic        ba_out,
    output logic [31:0] gp_output0,
    output logic [31:0] gp_output1,
    output logic [31:0] gp_output2,
    output logic [31:0] gp_output3,
    output logic [31:0] gp_output4,
    output logic [31:0] gp_output5,
    output logic [31:0] gp_output6,
    output logic [31:0] gp_output7,
    output logic [31:0] gp_output8,
    output logic [31:0] gp_output9,
    output logic [31:0] gp_output10,
    output logic [31:0] gp_output11,
    output logic [31:0] gp_output12,
    output logic [31:0] gp_output13,
    output logic [31:0] gp_output14,
    output logic [31:0] gp_output15,
    output logic [15:0] gp_out,
    output logic [31:0] c_sign_extended,
    output logic        sel_err
);

    import cpu_pkg::*;

    logic [31:0] bank_r [NREGS];
    logic        sel_err_r;
    reg_idx_t    sel_idx_s;
    logic        sel_en_s;
    logic [15:0] sel_hot_s;
    logic        multi_sel_s;
    logic        ba_eff_s;
    logic        unused_s;

`ifdef GP_BANK_BA_OUT_EN
    assign ba_eff_s = ba_out;
    assign unused_s = ^ir[31:27];
`else
    // Base-address drive has no meaning in this build.
    assign ba_eff_s = 1'b0;
    assign unused_s = ^{ir[31:27], ba_out};
`endif

    // Field select with gra > grb > grc priority.
    always_comb begin
        sel_idx_s = 4'd0;
        sel_en_s  = 1'b0;
        if (gra) begin
            sel_idx_s = ir[RA_MSB:RA_LSB];
            sel_en_s  = 1'b1;
        end else if (grb) begin
            sel_idx_s = ir[RB_MSB:RB_LSB];
            sel_en_s  = 1'b1;
        end else if (grc) begin
            sel_idx_s = ir[RC_MSB:RC_LSB];
            sel_en_s  = 1'b1;
        end else begin
            sel_idx_s = 4'd0;
            sel_en_s  = 1'b0;
        end
    end

    assign multi_sel_s = (gra & grb) | (gra & grc) | (grb & grc);

    reg_sel_decode u_sel_decode (
        .en  (sel_en_s),
        .idx (sel_idx_s),
        .hot (sel_hot_s)
    );

    assign gp_out          = sel_hot_s & {16{r_out | ba_eff_s}};
    assign c_sign_extended = sign_extend_c(ir[C_MSB:0]);

    // Register file storage; clear has priority over any load.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NREGS; i++) begin
                bank_r[i] <= 32'h0000_0000;
            end
        end else if (r_in && sel_en_s) begin
            bank_r[sel_idx_s] <= BusMuxOut;
        end
    end

    // Sticky flag for ambiguous multi-field selects on an active transfer.
    always_ff @(posedge clock) begin
        if (clear) begin
            sel_err_r <= 1'b0;
        end else if (multi_sel_s && (r_in || r_out)) begin
            sel_err_r <= 1'b1;
        end
    end

    assign sel_err = sel_err_r;

`ifdef GP_BANK_BA_OUT_EN
    // R0 reads as zero only while the base-address drive is active.
    assign gp_output0 = ba_out ? 32'h0000_0000 : bank_r[0];
`else
    assign gp_output0 = bank_r[0];
`endif
    assign gp_output1  = bank_r[1];
    assign gp_output2  = bank_r[2];
    assign gp_output3  = bank_r[3];
    assign gp_output4  = bank_r[4];
    assign gp_output5  = bank_r[5];
    assign gp_output6  = bank_r[6];
    assign gp_output7  = bank_r[7];
    assign gp_output8  = bank_r[8];
    assign gp_output9  = bank_r[9];
    assign gp_output10 = bank_r[10];
    assign gp_output11 = bank_r[11];
    assign gp_output12 = bank_r[12];
    assign gp_output13 = bank_r[13];
    assign gp_output14 = bank_r[14];
    assign gp_output15 = bank_r[15];

endmodule

// File: tb/tb_gp_reg_bank.sv
// Self-checking bench for gp_reg_bank: vector table with a scoreboard queue,
// plus hand-written multi-cycle sequences.
module tb_gp_reg_bank;

`ifdef GP_BANK_BA_OUT_EN
    localparam bit BA_EN = 1'b1;
`else
    localparam bit BA_EN = 1'b0;
`endif

    logic        clock;
    logic        clear;
    logic [31:0] BusMuxOut;
    logic [31:0] ir;
    logic        gra, grb, grc, r_in, r_out, ba_out;
    logic [31:0] gp_output0, gp_output1, gp_output2, gp_output3;
    logic [31:0] gp_output4, gp_output5, gp_output6, gp_output7;
    logic [31:0] gp_output8, gp_output9, gp_output10, gp_output11;
    logic [31:0] gp_output12, gp_output13, gp_output14, gp_output15;
    logic [15:0] gp_out;
    logic [31:0] c_sign_extended;
    logic        sel_err;

    gp_reg_bank dut (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .ir(ir),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .gp_output0(gp_output0), .gp_output1(gp_output1), .gp_output2(gp_output2),
        .gp_output3(gp_output3), .gp_output4(gp_output4), .gp_output5(gp_output5),
        .gp_output6(gp_output6), .gp_output7(gp_output7), .gp_output8(gp_output8),
        .gp_output9(gp_output9), .gp_output10(gp_output10), .gp_output11(gp_output11),
        .gp_output12(gp_output12), .gp_output13(gp_output13), .gp_output14(gp_output14),
        .gp_output15(gp_output15), .gp_out(gp_out), .c_sign_extended(c_sign_extended),
        .sel_err(sel_err)
    );

    logic [31:0] gpo [16];
    assign gpo[0]  = gp_output0;   assign gpo[1]  = gp_output1;
    assign gpo[2]  = gp_output2;   assign gpo[3]  = gp_output3;
    assign gpo[4]  = gp_output4;   assign gpo[5]  = gp_output5;
    assign gpo[6]  = gp_output6;   assign gpo[7]  = gp_output7;
    assign gpo[8]  = gp_output8;   assign gpo[9]  = gp_output9;
    assign gpo[10] = gp_output10;  assign gpo[11] = gp_output11;
    assign gpo[12] = gp_output12;  assign gpo[13] = gp_output13;
    assign gpo[14] = gp_output14;  assign gpo[15] = gp_output15;

    typedef struct {
        logic        clr;
        logic [3:0]  ra, rb, rc;
        logic        gra, grb, grc, rin, rout, ba;
        logic [31:0] bus;
        logic [15:0] exp_gp_out;
        logic [3:0]  chk_idx;
        logic [31:0] chk_val;
        logic        exp_err;
        logic        pre_en;
        logic [3:0]  pre_idx;
        logic [31:0] pre_val;
        string       name;
    } vec_t;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] val;
        logic        err;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [16];
    int          n_tests = 0;
    int          n_fail  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic clr, input logic [3:0] ra, input logic [3:0] rb,
                                input logic [3:0] rc, input logic g_a, input logic g_b,
                                input logic g_c, input logic rin, input logic rout,
                                input logic ba, input logic [31:0] bus, input logic [15:0] egp,
                                input logic [3:0] cidx, input logic [31:0] cval,
                                input logic eerr, input string name);
        vec_t v;
        v.clr = clr; v.ra = ra; v.rb = rb; v.rc = rc;
        v.gra = g_a; v.grb = g_b; v.grc = g_c; v.rin = rin; v.rout = rout; v.ba = ba;
        v.bus = bus; v.exp_gp_out = egp; v.chk_idx = cidx; v.chk_val = cval;
        v.exp_err = eerr; v.pre_en = 1'b0; v.pre_idx = 4'd0; v.pre_val = 32'h0;
        v.name = name;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        int   nsel;
        @(negedge clock);
        clear = v.clr; BusMuxOut = v.bus;
        ir = {5'b10101, v.ra, v.rb, v.rc, 15'h2A5A};
        gra = v.gra; grb = v.grb; grc = v.grc;
        r_in = v.rin; r_out = v.rout; ba_out = v.ba;
        #1;
        check32({v.name, " gp_out"}, {16'h0, gp_out}, {16'h0, v.exp_gp_out});
        if (v.pre_en) check32({v.name, " pre-edge reg"}, gpo[v.pre_idx], v.pre_val);
        e.idx = v.chk_idx; e.val = v.chk_val; e.err = v.exp_err; e.name = v.name;
        sb_q.push_back(e);
        @(posedge clock);
        // reference model of the bank contents
        if (v.clr) begin
            for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        end else if (v.rin && (v.gra || v.grb || v.grc)) begin
            mdl[v.gra ? v.ra : (v.grb ? v.rb : v.rc)] = v.bus;
        end
        nsel = int'(v.gra) + int'(v.grb) + int'(v.grc);
        #1;
        e = sb_q.pop_front();
        check32({e.name, " reg"}, gpo[e.idx], e.val);
        check32({e.name, " sel_err"}, {31'h0, sel_err}, {31'h0, e.err});
        for (int i = 0; i < 16; i++) begin
            check32($sformatf("%s bank[%0d]", e.name, i), gpo[i],
                    (i == 0 && BA_EN && v.ba) ? 32'h0 : mdl[i]);
        end
        if (nsel < 0) n_fail++;
    endtask

    vec_t tbl[$];
    vec_t v;
    logic [18:0] cfield;

    initial begin
        clear = 1'b1; BusMuxOut = 32'h0; ir = 32'h0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;

        tbl.push_back(mk(1'b1, 4'd0, 4'd0, 4'd0,  1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 32'h0, 16'h0000, 4'd0, 32'h0, 1'b0, "reset"));
        tbl.push_back(mk(1'b1, 4'd5, 4'd0, 4'd0,  1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 32'hDEAD0001, 16'h0020, 4'd5, 32'h0, 1'b0, "clear_blocks_write"));
        tbl.push_back(mk(1'b0, 4'd5, 4'd0, 4'd0,  1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, 32'hDEADBEEF, 16'h0000, 4'd5, 32'hDEADBEEF, 1'b0, "load_ra5"));
        tbl.push_back(mk(1'b0, 4'd5, 4'd0, 4'd0,  1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 32'h0, 16'h0020, 4'd5, 32'hDEADBEEF, 1'b0, "rout_ra5"));
        tbl.push_back(mk(1'b0, 4'd1, 4'd9, 4'd0,  1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0, 32'h0000_0909, 16'h0000, 4'd9, 32'h0000_0909, 1'b0, "load_rb9"));
        tbl.push_back(mk(1'b0, 4'd1, 4'd2, 4'd15, 1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 32'h0000_F0F0, 16'h8000, 4'd15, 32'h0000_F0F0, 1'b0, "load_rc15"));
        tbl.push_back(mk(1'b0, 4'd3, 4'd3, 4'd3,  1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 32'h0000_0BAD, 16'h0000, 4'd3, 32'h0, 1'b0, "no_strobe"));
        tbl.push_back(mk(1'b0, 4'd0, 4'd0, 4'd0,  1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, 32'h0000_0055, 16'h0000, 4'd0, 32'h0000_0055, 1'b0, "load_r0"));
        tbl.push_back(mk(1'b0, 4'd0, 4'd0, 4'd0,  1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1, 32'h0,
                         BA_EN ? 16'h0001 : 16'h0000, 4'd0, BA_EN ? 32'h0 : 32'h0000_0055, 1'b0, "ba_out_r0"));
        tbl.push_back(mk(1'b0, 4'd0, 4'd0, 4'd0,  1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 32'h0, 16'h0001, 4'd0, 32'h0000_0055, 1'b0, "rout_r0"));
        tbl.push_back(mk(1'b0, 4'd2, 4'd3, 4'd0,  1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0, 32'h0000_1234, 16'h0000, 4'd2, 32'h0000_1234, 1'b1, "prio_ab"));
        tbl.push_back(mk(1'b0, 4'd2, 4'd3, 4'd0,  1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 32'h0, 16'h0000, 4'd3, 32'h0, 1'b1, "err_sticky"));
        tbl.push_back(mk(1'b0, 4'd0, 4'd0, 4'd4,  1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0, 32'h0000_0044, 16'h0000, 4'd4, 32'h0000_0044, 1'b1, "err_hold_rc4"));
        tbl.push_back(mk(1'b1, 4'd0, 4'd0, 4'd0,  1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 32'h0, 16'h0000, 4'd2, 32'h0, 1'b0, "clear_err"));
        tbl.push_back(mk(1'b0, 4'd1, 4'd6, 4'd7,  1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0, 32'h0, 16'h0000, 4'd1, 32'h0, 1'b0, "multi_idle"));
        tbl.push_back(mk(1'b0, 4'd1, 4'd6, 4'd7,  1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0, 32'h0, 16'h0040, 4'd6, 32'h0, 1'b1, "err_rout_bc"));
        tbl.push_back(mk(1'b0, 4'd9, 4'd0, 4'd0,  1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1, 32'h0, 16'h0000, 4'd9, 32'h0, 1'b1, "ba_no_sel"));

        foreach (tbl[i]) apply(tbl[i]);

        // Read-modify-write: old value visible during the loading cycle.
        apply(mk(1'b0, 4'd7, 4'd0, 4'd0, 1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, 32'd10, 16'h0000, 4'd7, 32'd10, 1'b1, "rmw_setup"));
        v = mk(1'b0, 4'd7, 4'd0, 4'd0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 32'd11, 16'h0080, 4'd7, 32'd11, 1'b1, "rmw");
        v.pre_en = 1'b1; v.pre_idx = 4'd7; v.pre_val = 32'd10;
        apply(v);

        // Held r_in: each cycle rewrites, last bus value wins.
        for (int k = 1; k <= 3; k++) begin
            v = mk(1'b0, 4'd8, 4'd0, 4'd0, 1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, 32'hA000_0000 + 32'(k),
                   16'h0000, 4'd8, 32'hA000_0000 + 32'(k), 1'b1, $sformatf("hold_%0d", k));
            if (k > 1) begin
                v.pre_en = 1'b1; v.pre_idx = 4'd8; v.pre_val = 32'hA000_0000 + 32'(k - 1);
            end
            apply(v);
        end
        apply(mk(1'b0, 4'd8, 4'd0, 4'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 32'h0, 16'h0000, 4'd8, 32'hA000_0003, 1'b1, "hold_final"));

        // Clear mid-sequence with a pending write wipes everything.
        apply(mk(1'b0, 4'd1, 4'd0, 4'd0, 1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, 32'h0000_00AA, 16'h0000, 4'd1, 32'h0000_00AA, 1'b1, "mid_setup"));
        apply(mk(1'b1, 4'd1, 4'd0, 4'd0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 32'h0000_0077, 16'h0002, 4'd1, 32'h0, 1'b0, "mid_clear"));

        // Sign extension of the C field, independent of upper IR bits.
        @(negedge clock);
        gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0; clear = 1'b0;
        cfield = 19'h40000; ir = {13'h0000, cfield};
        #1 check32("sext_neg", c_sign_extended, 32'hFFFC_0000);
        cfield = 19'h3FFFF; ir = {13'h1FFF, cfield};
        #1 check32("sext_pos", c_sign_extended, 32'h0003_FFFF);
        cfield = 19'h7FFFF; ir = {13'h0A5A, cfield};
        #1 check32("sext_all_ones", c_sign_extended, 32'hFFFF_FFFF);
        cfield = 19'h00001; ir = {13'h1555, cfield};
        #1 check32("sext_one", c_sign_extended, 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
